// File: rtl/pipeline_scoreboard_if.sv
// Issue/writeback bundle between the scoreboard wrapper and its core, also reused
// by the bench to carry stimulus and observed outputs.
interface pipeline_scoreboard_if #(
  parameter int NREG    = 32,
  parameter int LAT_W   = 4,
  parameter int MAX_VAR = 2
);
  localparam int ADDR_W = $clog2(NREG);
  localparam int CNT_W  = $clog2(MAX_VAR + 1);

  logic              issue_valid;
  logic              issue_wen;
  logic [ADDR_W-1:0] issue_rd;
  logic [LAT_W-1:0]  issue_lat;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1_used;
  logic              rs2_used;
  logic              flush;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic              stall;
  logic              issue_fire;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  var_cnt;

  // Handshake: an ID-stage instruction is accepted (issue_fire) in the cycle
  // issue_valid is high, flush is low and stall is low; stall holds the ID stage.
  modport master (
    output issue_valid, issue_wen, issue_rd, issue_lat, rs1, rs2, rs1_used, rs2_used,
           flush, wb_valid, wb_rd,
    input  stall, issue_fire, busy, var_cnt
  );

  modport slave (
    input  issue_valid, issue_wen, issue_rd, issue_lat, rs1, rs2, rs1_used, rs2_used,
           flush, wb_valid, wb_rd,
    output stall, issue_fire, busy, var_cnt
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Register scoreboard for an in-order pipeline: tracks pending fixed- and
// variable-latency writes and stalls the ID stage on RAW/WAW hazards.
module pipeline_scoreboard_core #(
  parameter int NREG    = 32,
  parameter int LAT_W   = 4,
  parameter int MAX_VAR = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  pipeline_scoreboard_if.slave sb
);
  localparam int ADDR_W = $clog2(NREG);
  localparam int CNT_W  = $clog2(MAX_VAR + 1);
  localparam logic [LAT_W-1:0] LAT_VAR = '1;
  localparam logic [CNT_W-1:0] VAR_MAX = CNT_W'(MAX_VAR);

  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  r_var;
  logic [LAT_W-1:0] r_cnt [NREG];
  logic [CNT_W-1:0] r_var_cnt;

  logic w_raw1, w_raw2, w_waw, w_var_full, w_req, w_stall, w_fire;
  logic w_alloc, w_alloc_var, w_retire;

  // Hazards look only at registered state, so a same-cycle writeback does not unstall.
  assign w_raw1      = sb.rs1_used && r_busy[sb.rs1] && (sb.rs1 != '0);
  assign w_raw2      = sb.rs2_used && r_busy[sb.rs2] && (sb.rs2 != '0);
  assign w_waw       = sb.issue_wen && r_busy[sb.issue_rd] && (sb.issue_rd != '0);
  assign w_var_full  = (sb.issue_lat == LAT_VAR) && (r_var_cnt == VAR_MAX);
  assign w_req       = sb.issue_valid && !sb.flush;
  assign w_stall     = w_req && (w_raw1 || w_raw2 || w_waw || w_var_full);
  assign w_fire      = w_req && !w_stall;

  assign w_alloc     = w_fire && sb.issue_wen && (sb.issue_rd != '0) && (sb.issue_lat != '0);
  assign w_alloc_var = w_alloc && (sb.issue_lat == LAT_VAR);
  assign w_retire    = sb.wb_valid && (sb.wb_rd != '0) && r_var[sb.wb_rd];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy    <= '0;
      r_var     <= '0;
      r_var_cnt <= '0;
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      // Entry 0 is never written, so x0 stays permanently free.
      for (int i = 1; i < NREG; i++) begin
        if (!r_var[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
          if (r_cnt[i] == LAT_W'(1)) r_busy[i] <= 1'b0;
        end
        if (w_retire && (sb.wb_rd == ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
          r_var[i]  <= 1'b0;
        end
        // WAW stalling guarantees an allocated entry is idle, so no conflict with the above.
        if (w_alloc && (sb.issue_rd == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_var[i]  <= w_alloc_var;
          r_cnt[i]  <= w_alloc_var ? '0 : sb.issue_lat;
        end
      end
      case ({w_alloc_var, w_retire})
        2'b10:   r_var_cnt <= r_var_cnt + 1'b1;
        2'b01:   r_var_cnt <= r_var_cnt - 1'b1;
        default: r_var_cnt <= r_var_cnt;
      endcase
    end
  end

  assign sb.stall      = w_stall;
  assign sb.issue_fire = w_fire;
  assign sb.busy       = r_busy;
  assign sb.var_cnt    = r_var_cnt;
endmodule

module pipeline_scoreboard #(
  parameter int NREG    = 32,
  parameter int LAT_W   = 4,
  parameter int MAX_VAR = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           issue_valid_i,
  input  logic                           issue_wen_i,
  input  logic [$clog2(NREG)-1:0]        issue_rd_i,
  input  logic [LAT_W-1:0]               issue_lat_i,
  input  logic [$clog2(NREG)-1:0]        rs1_i,
  input  logic [$clog2(NREG)-1:0]        rs2_i,
  input  logic                           rs1_used_i,
  input  logic                           rs2_used_i,
  input  logic                           flush_i,
  input  logic                           wb_valid_i,
  input  logic [$clog2(NREG)-1:0]        wb_rd_i,
  output logic                           stall_o,
  output logic                           issue_fire_o,
  output logic [NREG-1:0]                busy_o,
  output logic [$clog2(MAX_VAR+1)-1:0]   var_cnt_o
);
  pipeline_scoreboard_if #(.NREG(NREG), .LAT_W(LAT_W), .MAX_VAR(MAX_VAR)) u_sb_if ();

  assign u_sb_if.issue_valid = issue_valid_i;
  assign u_sb_if.issue_wen   = issue_wen_i;
  assign u_sb_if.issue_rd    = issue_rd_i;
  assign u_sb_if.issue_lat   = issue_lat_i;
  assign u_sb_if.rs1         = rs1_i;
  assign u_sb_if.rs2         = rs2_i;
  assign u_sb_if.rs1_used    = rs1_used_i;
  assign u_sb_if.rs2_used    = rs2_used_i;
  assign u_sb_if.flush       = flush_i;
  assign u_sb_if.wb_valid    = wb_valid_i;
  assign u_sb_if.wb_rd       = wb_rd_i;

  pipeline_scoreboard_core #(.NREG(NREG), .LAT_W(LAT_W), .MAX_VAR(MAX_VAR)) u_core (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sb      (u_sb_if)
  );

  assign stall_o      = u_sb_if.stall;
  assign issue_fire_o = u_sb_if.issue_fire;
  assign busy_o       = u_sb_if.busy;
  assign var_cnt_o    = u_sb_if.var_cnt;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard (NREG=32, LAT_W=4 so LAT_VAR=15, MAX_VAR=2).
module tb_pipeline_scoreboard;
  localparam int NREG = 32;
  localparam int LAT_W = 4;
  localparam int MAX_VAR = 2;
  localparam logic [LAT_W-1:0] LV = '1;

  logic clk_i = 1'b0;
  logic rst_n_i;
  int   n_assert = 0;
  int   n_fail = 0;

  pipeline_scoreboard_if #(.NREG(NREG), .LAT_W(LAT_W), .MAX_VAR(MAX_VAR)) tb_if ();

  pipeline_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .MAX_VAR(MAX_VAR)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .issue_valid_i (tb_if.issue_valid),
    .issue_wen_i   (tb_if.issue_wen),
    .issue_rd_i    (tb_if.issue_rd),
    .issue_lat_i   (tb_if.issue_lat),
    .rs1_i         (tb_if.rs1),
    .rs2_i         (tb_if.rs2),
    .rs1_used_i    (tb_if.rs1_used),
    .rs2_used_i    (tb_if.rs2_used),
    .flush_i       (tb_if.flush),
    .wb_valid_i    (tb_if.wb_valid),
    .wb_rd_i       (tb_if.wb_rd),
    .stall_o       (tb_if.stall),
    .issue_fire_o  (tb_if.issue_fire),
    .busy_o        (tb_if.busy),
    .var_cnt_o     (tb_if.var_cnt)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    tb_if.issue_valid = 1'b0;
    tb_if.issue_wen   = 1'b0;
    tb_if.issue_rd    = '0;
    tb_if.issue_lat   = '0;
    tb_if.rs1         = '0;
    tb_if.rs2         = '0;
    tb_if.rs1_used    = 1'b0;
    tb_if.rs2_used    = 1'b0;
    tb_if.flush       = 1'b0;
    tb_if.wb_valid    = 1'b0;
    tb_if.wb_rd       = '0;
  endtask

  task automatic issue_wr(input int rd, input int lat);
    idle();
    tb_if.issue_valid = 1'b1;
    tb_if.issue_wen   = 1'b1;
    tb_if.issue_rd    = 5'(rd);
    tb_if.issue_lat   = LAT_W'(lat);
  endtask

  task automatic issue_rd1(input int rs);
    idle();
    tb_if.issue_valid = 1'b1;
    tb_if.rs1         = 5'(rs);
    tb_if.rs1_used    = 1'b1;
  endtask

  // checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_io(input string tag, input logic st, input logic fi);
    #1;
    chk({tag, "_stall"}, 64'(tb_if.stall), 64'(st));
    chk({tag, "_fire"},  64'(tb_if.issue_fire), 64'(fi));
  endtask

  initial begin
    idle();
    rst_n_i = 1'b0;
    #2;
    chk("rst_busy", 64'(tb_if.busy), 64'd0);
    chk("rst_varcnt", 64'(tb_if.var_cnt), 64'd0);
    chk_io("rst_idle", 1'b0, 1'b0);
    tick();
    tick();
    rst_n_i = 1'b1;

    // RAW on a 2-cycle fixed-latency result, usable straight out of reset
    issue_wr(5, 2);
    chk_io("raw_t0", 1'b0, 1'b1);
    tick();
    issue_rd1(5);
    chk_io("raw_t1", 1'b1, 1'b0);
    chk("raw_busy_t1", 64'(tb_if.busy), 64'h20);
    tick();
    chk_io("raw_t2", 1'b1, 1'b0);
    tick();
    chk_io("raw_t3", 1'b0, 1'b1);
    chk("raw_busy_t3", 64'(tb_if.busy), 64'h0);
    tick();

    // writes to x0 never mark busy
    issue_wr(0, 3);
    chk_io("x0_wr", 1'b0, 1'b1);
    tick();
    issue_rd1(0);
    chk_io("x0_dep", 1'b0, 1'b1);
    chk("x0_busy", 64'(tb_if.busy), 64'h0);
    tick();

    // variable-latency capacity
    issue_wr(7, 15);
    chk_io("var7", 1'b0, 1'b1);
    tick();
    issue_wr(8, 15);
    chk_io("var8", 1'b0, 1'b1);
    chk("var_cnt1", 64'(tb_if.var_cnt), 64'd1);
    tick();
    issue_wr(9, 15);
    tb_if.wb_valid = 1'b1;
    tb_if.wb_rd    = 5'd7;
    chk_io("var_full", 1'b1, 1'b0);
    chk("var_cnt2", 64'(tb_if.var_cnt), 64'd2);
    chk("var_busy2", 64'(tb_if.busy), 64'h180);
    tick();
    tb_if.wb_valid = 1'b0;
    chk_io("var9_fire", 1'b0, 1'b1);
    tick();
    chk("var_cnt_after9", 64'(tb_if.var_cnt), 64'd2);
    chk("var_busy_after9", 64'(tb_if.busy), 64'h300);
    idle();
    tb_if.wb_valid = 1'b1;
    tb_if.wb_rd    = 5'd8;
    tick();
    chk("var_cnt_wb8", 64'(tb_if.var_cnt), 64'd1);
    issue_wr(10, 15);
    tb_if.wb_valid = 1'b1;
    tb_if.wb_rd    = 5'd9;
    chk_io("var_net", 1'b0, 1'b1);
    tick();
    chk("var_cnt_net", 64'(tb_if.var_cnt), 64'd1);
    chk("var_busy_net", 64'(tb_if.busy), 64'h400);
    idle();
    tb_if.wb_valid = 1'b1;
    tb_if.wb_rd    = 5'd10;
    tick();
    tick();
    chk("var_cnt_nounder", 64'(tb_if.var_cnt), 64'd0);
    chk("var_busy_clear", 64'(tb_if.busy), 64'h0);
    idle();

    // WAW behind a 4-cycle write
    issue_wr(3, 4);
    chk_io("waw_t0", 1'b0, 1'b1);
    tick();
    issue_wr(3, 1);
    for (int c = 1; c <= 4; c++) begin
      chk_io($sformatf("waw_stall%0d", c), 1'b1, 1'b0);
      tick();
    end
    chk_io("waw_fire", 1'b0, 1'b1);
    tick();
    idle();
    chk("waw_busy_1cyc", 64'(tb_if.busy), 64'h8);
    tick();
    chk("waw_busy_done", 64'(tb_if.busy), 64'h0);

    // flush squashes a stalled instruction, stray writeback is ignored
    issue_wr(6, 2);
    tick();
    idle();
    tb_if.issue_valid = 1'b1;
    tb_if.rs2         = 5'd6;
    tb_if.rs2_used    = 1'b1;
    chk_io("flush_pre", 1'b1, 1'b0);
    tb_if.flush    = 1'b1;
    tb_if.wb_valid = 1'b1;
    tb_if.wb_rd    = 5'd9;
    chk_io("flush", 1'b0, 1'b0);
    tb_if.flush       = 1'b0;
    tb_if.issue_valid = 1'b0;
    chk_io("novalid", 1'b0, 1'b0);
    tick();
    chk("flush_busy", 64'(tb_if.busy), 64'h40);
    chk("flush_varcnt", 64'(tb_if.var_cnt), 64'd0);
    idle();
    tick();
    chk("flush_busy_done", 64'(tb_if.busy), 64'h0);

    // asynchronous reset mid-flight
    issue_wr(4, 15);
    tick();
    idle();
    chk("pre_rst_varcnt", 64'(tb_if.var_cnt), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_busy", 64'(tb_if.busy), 64'h0);
    chk("async_varcnt", 64'(tb_if.var_cnt), 64'd0);
    tick();
    rst_n_i = 1'b1;
    tb_if.wb_valid = 1'b1;
    tb_if.wb_rd    = 5'd4;
    tick();
    chk("late_wb_varcnt", 64'(tb_if.var_cnt), 64'd0);
    chk("late_wb_busy", 64'(tb_if.busy), 64'h0);
    issue_rd1(4);
    chk_io("post_rst_dep", 1'b0, 1'b1);
    tick();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: number of architectural integer registers; ADDR_W = clog2(NREG).
REQ-002 SHALL have parameter LAT_W, default 4: latency field width; LAT_VAR = all-ones(LAT_W) encodes variable latency.
REQ-003 SHALL have parameter MAX_VAR, default 2: maximum outstanding variable-latency writes, range 1..NREG-1.
REQ-004 SHALL have port clk_i, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port issue_valid_i, input, 1: ID-stage instruction present.
REQ-007 SHALL have port issue_wen_i, input, 1: instruction writes rd.
REQ-008 SHALL have port issue_rd_i, input, ADDR_W: destination register.
REQ-009 SHALL have port issue_lat_i, input, LAT_W: cycles until the result is forwardable.
REQ-010 SHALL have ports rs1_i and rs2_i, input, ADDR_W each: source registers.
REQ-011 SHALL have ports rs1_used_i and rs2_used_i, input, 1 each: the matching source is read.
REQ-012 SHALL have port flush_i, input, 1: squash the ID-stage instruction this cycle.
REQ-013 SHALL have port wb_valid_i, input, 1: variable-latency unit completion.
REQ-014 SHALL have port wb_rd_i, input, ADDR_W: completing register.
REQ-015 SHALL have port stall_o, output, 1: hold the ID stage and all earlier stages.
REQ-016 SHALL have port issue_fire_o, output, 1: instruction accepted this cycle.
REQ-017 SHALL have port busy_o, output, NREG: per-register pending-write bitmap.
REQ-018 SHALL have port var_cnt_o, output, clog2(MAX_VAR+1): outstanding variable-latency writes.

Function
REQ-019 SHALL keep per register r a busy bit, a down-counter cnt[r] (LAT_W bits) and a var flag; register 0 SHALL never be busy.
REQ-020 SHALL evaluate hazards from registered state only, combinationally: RAW = rsN_used_i and busy[rsN_i] and rsN_i != 0.
REQ-021 SHALL detect WAW = issue_wen_i and busy[issue_rd_i] and issue_rd_i != 0.
REQ-022 SHALL detect var-full = issue_lat_i == LAT_VAR and var_cnt == MAX_VAR.
REQ-023 SHALL drive stall_o = issue_valid_i and not flush_i and (RAW or WAW or var-full).
REQ-024 SHALL drive issue_fire_o = issue_valid_i and not flush_i and not stall_o.
REQ-025 On fire with wen, rd != 0 and lat = 0, SHALL change no state.
REQ-026 On fire with wen, rd != 0 and lat k in 1..LAT_VAR-1, SHALL set busy[rd] and load cnt[rd] = k.
REQ-027 For a fixed-latency entry, busy SHALL hold during cycles t+1..t+k after fire at cycle t; a dependent SHALL fire no earlier than t+k+1.
REQ-028 Each cycle, a fixed entry with cnt != 0 SHALL decrement, and SHALL clear busy on the edge where cnt goes 1 to 0.
REQ-029 On fire with lat = LAT_VAR, SHALL set busy[rd] and var[rd] and increment var_cnt; the entry SHALL stay busy until wb_valid_i with wb_rd_i == rd.
REQ-030 On wb_valid_i to a var-busy register, SHALL clear busy and var and decrement var_cnt.
REQ-031 SHALL ignore wb_valid_i to a register that is not var-busy, or to register 0; state SHALL be unchanged.
REQ-032 SHALL net a same-cycle variable-latency fire and a wb completion in var_cnt, leaving it unchanged.
REQ-033 SHALL never overflow or underflow var_cnt.
REQ-034 flush_i SHALL squash only the ID-stage instruction; in-flight (older) entries SHALL be unaffected.
REQ-035 SHALL keep stall_o and issue_fire_o 0 when issue_valid_i = 0.

Reset
REQ-036 While rst_n_i = 0, SHALL immediately (asynchronously) clear all busy bits, counters, var flags and var_cnt_o; busy_o = 0.
REQ-037 Reset asserted mid-operation SHALL discard all pending entries; a late wb_valid_i after reset SHALL be ignored.
REQ-038 After reset, stall_o and issue_fire_o SHALL follow REQ-023/REQ-024 directly from inputs, with no extra warm-up cycle.

Verification
REQ-039 Fire rd=5, lat=2 at t; next instruction rs1=5 -> stall_o=1 at t+1 and t+2, issue_fire_o=1 at t+3; busy_o[5]=0 from t+3.
REQ-040 Fire rd=0, lat=3 -> busy_o stays 0; a dependent on x0 fires the next cycle.
REQ-041 Fire rd=7 and rd=8 with lat=LAT_VAR (MAX_VAR=2), then a third LAT_VAR issue -> stall_o=1, var_cnt_o=2; wb_rd_i=7 -> third fires the next cycle, var_cnt_o stays 2.
REQ-042 Fire rd=3, lat=4; then issue wen rd=3, lat=1 -> WAW stall for 4 cycles, then fire; busy_o[3]=1 for 1 cycle.
REQ-043 RAW stall with flush_i=1 -> stall_o=0, issue_fire_o=0, no state change; wb_rd_i=9 with reg 9 not busy -> no change.
REQ-044 Fire rd=4, LAT_VAR; assert rst_n_i mid-flight -> busy_o=0 and var_cnt_o=0 immediately; later wb_rd_i=4 is ignored.
